alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL take parameter NIBBLES, default 2, meaning the number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 The module SHALL use exactly one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_op  in  2  ALUOP code forwarded to the ALU.
- cmd_l  in  1  0 = arithmetic, 1 = logic, forwarded to the ALU.
- cmd_cin  in  1  carry-in for slice 0.
- cmd_chain  in  1  1 = slice-0 carry-in taken from the saved carry of the previous operation instead of cmd_cin.
- alu_a  out  4  nibble of A driven to the 4-bit ALU.
- alu_b  out  4  nibble of B driven to the 4-bit ALU.
- alu_c_in  out  1  carry driven to the ALU.
- alu_op  out  2  ALUOP driven to the ALU.
- alu_l  out  1  l driven to the ALU.
- alu_r  in  4  ALU result (combinational response to the alu_* outputs in the same cycle).
- alu_c_out  in  1  ALU carry-out.
- alu_zero  in  1  ALU zero flag.
- alu_sign  in  1  ALU sign flag.
- res_valid  out  1  result held.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_r  out  W  assembled result.
- res_c_out  out  1  carry-out of the final slice.
- res_zero  out  1  1 when all slices reported zero.
- res_sign  out  1  sign flag of the final slice.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN, DONE. It SHALL use a slice counter idx of width ceil(log2(NIBBLES)), minimum 1.
REQ-004 cmd_ready SHALL be 1 only in IDLE. On acceptance, the module SHALL latch cmd_a, cmd_b, cmd_op, cmd_l, and the effective cin (cmd_chain ? saved_carry : cmd_cin), set idx=0, and go to RUN.
REQ-005 In RUN, the alu_* outputs SHALL be driven as follows:
- alu_a/alu_b = latched operand nibble [4*idx+3:4*idx].
- alu_op/alu_l = latched values.
- alu_c_in: effective cin for idx=0; for idx>0, the alu_c_out captured from slice idx-1 when l=0, else 0.
REQ-006 At each RUN edge, the module SHALL write alu_r into res_r nibble idx, capture alu_c_out, and AND alu_zero into a running zero accumulator that is initialised to 1 at acceptance.
REQ-007 When idx = NIBBLES-1, the module SHALL also capture alu_sign, set res_c_out = alu_c_out, load saved_carry = alu_c_out, and go to DONE; otherwise it SHALL increment idx.
REQ-008 Latency SHALL be as follows: command accepted at edge k gives res_valid=1 from the cycle after edge k+NIBBLES (3 cycles for NIBBLES=2).
REQ-009 In DONE, res_valid SHALL be 1 and res_r/res_c_out/res_zero/res_sign SHALL be stable until handshake. On res_valid & res_ready, the FSM SHALL go to IDLE; res_* SHALL retain their values and res_valid SHALL drop.
REQ-010 cmd_valid asserted in RUN or DONE SHALL be ignored, with no acceptance and no state change; a command offered in the same cycle as the result handshake SHALL be accepted no earlier than the next cycle, in IDLE.
REQ-011 Outside RUN, alu_a, alu_b, alu_c_in, alu_op, and alu_l SHALL be driven to 0.
REQ-012 saved_carry SHALL change only on completion of an operation. cmd_chain=1 SHALL use saved_carry regardless of the l of either operation.
REQ-013 res_r widths SHALL be exact; no carry SHALL be folded into res_r. The carry out of the top slice SHALL appear only on res_c_out.

Reset
REQ-014 Reset SHALL force the following on the next edge: state=IDLE, idx=0, saved_carry=0, zero accumulator=1, res_r=0, res_c_out=0, res_zero=0, res_sign=0, and res_valid=0; cmd_ready SHALL be 1 in the first cycle after reset.
REQ-015 Reset asserted in RUN or DONE SHALL abort the operation, discard partial results, and take priority over any handshake in that cycle.

Verification (NIBBLES=2; bench ALU stub: l=0 -> {c_out,R}=A+B+c_in; l=1 -> R=A&B, c_out=0; zero=(R==0); sign=R[3])
REQ-016 The bench SHALL cover: cmd a=8'h3A, b=8'h07, l=0, cin=0, chain=0 -> slice0 alu_a=4'hA, alu_b=4'h7, alu_c_in=0; slice1 alu_c_in=1; res_r=8'h41, res_c_out=0, res_zero=0, res_sign=0, res_valid 3 cycles after acceptance.
REQ-017 The bench SHALL cover: a=8'hFF, b=8'h01, l=0 -> res_r=8'h00, res_c_out=1, res_zero=1, res_sign=0; then a=8'h00, b=8'h00, chain=1 -> slice0 alu_c_in=1, res_r=8'h01, res_zero=0.
REQ-018 The bench SHALL cover: a=8'hF0, b=8'h0F, l=1 -> both slices alu_c_in=0, res_r=8'h00, res_zero=1; then a=8'hC3, b=8'hF0, l=1 -> res_r=8'hC0, res_sign=1.
REQ-019 The bench SHALL cover: hold res_ready=0 for 5 cycles in DONE while cmd_valid=1 -> res_valid and res_* stable, cmd_ready=0, no acceptance; on res_ready=1, cmd_ready=1 the next cycle.
REQ-020 The bench SHALL cover: reset asserted in the RUN cycle of slice 1 -> next cycle state IDLE, res_valid=0, res_r=0, and a subsequent chain=1 command drives alu_c_in=0.
REQ-021 The bench SHALL cover: back-to-back commands with cmd_valid held high and res_ready=1 -> one acceptance per 4 cycles, and alu_* outputs = 0 in IDLE and DONE.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: runs a W-bit operation through an external 4-bit ALU one nibble
// per cycle. Slice carries ripple from one nibble to the next. The carry of
// the final slice is kept so that a later command can chain from it.
module alu_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  // command channel
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  input  logic [1:0]             cmd_op,
  input  logic                   cmd_l,
  input  logic                   cmd_cin,
  input  logic                   cmd_chain,
  // 4-bit ALU interface
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_c_in,
  output logic [1:0]             alu_op,
  output logic                   alu_l,
  input  logic [3:0]             alu_r,
  input  logic                   alu_c_out,
  input  logic                   alu_zero,
  input  logic                   alu_sign,
  // result channel
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_r,
  output logic                   res_c_out,
  output logic                   res_zero,
  output logic                   res_sign
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;

  // Command copy taken at acceptance.
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [1:0]         r_op;
  logic               r_l;
  logic               r_cin;

  logic               r_slice_carry;   // carry out of the slice just processed
  logic               r_saved_carry;   // carry out of the last completed operation
  logic               r_zero_acc;      // AND of the zero flags seen so far

  logic [W-1:0]       r_res_r;
  logic               r_res_c_out;
  logic               r_res_zero;
  logic               r_res_sign;

  logic               w_accept;
  logic               w_last;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_a_nib  = r_a[4*r_idx +: 4];
  assign w_b_nib  = r_b[4*r_idx +: 4];

  assign res_r     = r_res_r;
  assign res_c_out = r_res_c_out;
  assign res_zero  = r_res_zero;
  assign res_sign  = r_res_sign;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values regardless of the order of the always blocks.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: one RUN cycle per nibble; DONE is held until the result is taken.
  always_comb begin
    // NOTE: the default assignment comes first so that no path through the
    // case statement leaves the signal unassigned, which would infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: handshakes follow the state; the ALU sees the current slice only in RUN.
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    res_valid = (r_state == S_DONE);
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_c_in  = 1'b0;
    alu_op    = 2'b00;
    alu_l     = 1'b0;
    if (r_state == S_RUN) begin
      alu_a  = w_a_nib;
      alu_b  = w_b_nib;
      alu_op = r_op;
      alu_l  = r_l;
      if (r_idx == '0) alu_c_in = r_cin;
      else             alu_c_in = r_l ? 1'b0 : r_slice_carry;
    end
  end

  // Command operand capture.
  // NOTE: the operand copy has no reset. It is loaded on every acceptance and
  // is read only in RUN, so its value after reset is never observed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= cmd_a;
      r_b  <= cmd_b;
      r_op <= cmd_op;
      r_l  <= cmd_l;
    end
  end

  // Slice sequencing, result assembly, and carry bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx         <= '0;
      r_cin         <= 1'b0;
      r_slice_carry <= 1'b0;
      r_saved_carry <= 1'b0;
      r_zero_acc    <= 1'b1;
      r_res_r       <= '0;
      r_res_c_out   <= 1'b0;
      r_res_zero    <= 1'b0;
      r_res_sign    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cin      <= cmd_chain ? r_saved_carry : cmd_cin;
            r_idx      <= '0;
            r_zero_acc <= 1'b1;
          end
        end
        S_RUN: begin
          r_res_r[4*r_idx +: 4] <= alu_r;
          r_slice_carry         <= alu_c_out;
          r_zero_acc            <= r_zero_acc & alu_zero;
          if (w_last) begin
            r_res_sign    <= alu_sign;
            r_res_c_out   <= alu_c_out;
            r_res_zero    <= r_zero_acc & alu_zero;
            r_saved_carry <= alu_c_out;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives alu_seq (NIBBLES=2) in front of a behavioural 4-bit ALU
// and compares each slice and each result with values computed from whole-word
// arithmetic.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic       cmd_l, cmd_cin, cmd_chain;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_c_in, alu_l, alu_c_out, alu_zero, alu_sign;
  logic [1:0] alu_op;
  logic       res_valid, res_ready;
  logic [7:0] res_r;
  logic       res_c_out, res_zero, res_sign;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic m_saved;       // carry saved by the last completed operation
  bit   b2b = 1'b0;    // keep cmd_valid and res_ready high between operations
  bit   have_prev = 1'b0;
  int   prev_acc = 0;

  alu_seq #(.NIBBLES(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_l(cmd_l),
    .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_op(alu_op), .alu_l(alu_l),
    .alu_r(alu_r), .alu_c_out(alu_c_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_c_out(res_c_out), .res_zero(res_zero), .res_sign(res_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit ALU.
  always_comb begin
    if (alu_l) begin
      alu_r     = alu_a & alu_b;
      alu_c_out = 1'b0;
    end else begin
      {alu_c_out, alu_r} = 5'(alu_a) + 5'(alu_b) + 5'(alu_c_in);
    end
    alu_zero = (alu_r == 4'h0);
    alu_sign = alu_r[3];
  end

  // One full command: accept, two slices, DONE (optionally stalled), handshake, IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic l, input logic cin, input logic chain,
                        input int hold, input string name);
    logic       eff, c1, exp_c, exp_z, exp_s;
    logic [4:0] lo;
    logic [8:0] full;
    logic [7:0] exp_r;
    int         n;
    eff   = chain ? m_saved : cin;
    lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, eff};
    c1    = l ? 1'b0 : lo[4];
    full  = {1'b0, a} + {1'b0, b} + {8'b0, eff};
    exp_r = l ? (a & b) : full[7:0];
    exp_c = l ? 1'b0 : full[8];
    exp_z = (exp_r == 8'h00);
    exp_s = exp_r[7];

    cmd_a = a; cmd_b = b; cmd_op = op; cmd_l = l; cmd_cin = cin; cmd_chain = chain;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s accept_timeout cmd_ready got %b exp 1", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (b2b && have_prev) begin
      n_checks++;
      if (cyc - prev_acc !== 4) begin n_fail++; $display("FAIL %s b2b_spacing got %0d exp 4", name, cyc - prev_acc); end
    end
    prev_acc = cyc; have_prev = 1'b1;
    if (!b2b) cmd_valid = 1'b0;

    // Slice 0
    @(negedge clk);
    n_checks++; if (alu_a !== a[3:0])    begin n_fail++; $display("FAIL %s s0_alu_a got %h exp %h", name, alu_a, a[3:0]); end
    n_checks++; if (alu_b !== b[3:0])    begin n_fail++; $display("FAIL %s s0_alu_b got %h exp %h", name, alu_b, b[3:0]); end
    n_checks++; if (alu_c_in !== eff)    begin n_fail++; $display("FAIL %s s0_alu_c_in got %b exp %b", name, alu_c_in, eff); end
    n_checks++; if (alu_op !== op || alu_l !== l) begin n_fail++; $display("FAIL %s s0_op_l got %b/%b exp %b/%b", name, alu_op, alu_l, op, l); end
    n_checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL %s s0_handshake got %b/%b exp 0/0", name, cmd_ready, res_valid); end

    // Slice 1
    @(negedge clk);
    n_checks++; if (alu_a !== a[7:4])    begin n_fail++; $display("FAIL %s s1_alu_a got %h exp %h", name, alu_a, a[7:4]); end
    n_checks++; if (alu_b !== b[7:4])    begin n_fail++; $display("FAIL %s s1_alu_b got %h exp %h", name, alu_b, b[7:4]); end
    n_checks++; if (alu_c_in !== c1)     begin n_fail++; $display("FAIL %s s1_alu_c_in got %b exp %b", name, alu_c_in, c1); end
    n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL %s s1_res_valid got %b exp 0", name, res_valid); end

    // DONE, first cycle and any stall cycles
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL %s done%0d_res_valid got %b exp 1", name, i, res_valid); end
      n_checks++; if (res_r !== exp_r)    begin n_fail++; $display("FAIL %s done%0d_res_r got %h exp %h", name, i, res_r, exp_r); end
      n_checks++; if (res_c_out !== exp_c || res_zero !== exp_z || res_sign !== exp_s) begin
        n_fail++; $display("FAIL %s done%0d_flags c/z/s got %b%b%b exp %b%b%b", name, i, res_c_out, res_zero, res_sign, exp_c, exp_z, exp_s); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s done%0d_cmd_ready got %b exp 0", name, i, cmd_ready); end
      n_checks++; if ({alu_a, alu_b, alu_c_in, alu_op, alu_l} !== 12'h000) begin
        n_fail++; $display("FAIL %s done%0d_alu_idle got %h exp 000", name, i, {alu_a, alu_b, alu_c_in, alu_op, alu_l}); end
      if (i < hold) begin
        // Offer a different command while the result is pending; it must be ignored.
        cmd_valid = 1'b1; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_chain = 1'b0;
      end
    end
    m_saved = exp_c;

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = b2b;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_handshake valid/ready got %b/%b exp 0/1", name, res_valid, cmd_ready); end
    n_checks++; if (res_r !== exp_r || res_c_out !== exp_c) begin
      n_fail++; $display("FAIL %s idle_retain got %h/%b exp %h/%b", name, res_r, res_c_out, exp_r, exp_c); end
    n_checks++; if ({alu_a, alu_b, alu_c_in, alu_op, alu_l} !== 12'h000) begin
      n_fail++; $display("FAIL %s idle_alu got %h exp 000", name, {alu_a, alu_b, alu_c_in, alu_op, alu_l}); end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_l = 1'b0; cmd_cin = 1'b0; cmd_chain = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_saved = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset res_valid got %b exp 0", res_valid); end
    n_checks++; if (res_r !== 8'h00)    begin n_fail++; $display("FAIL reset res_r got %h exp 00", res_r); end
    n_checks++; if ({res_c_out, res_zero, res_sign} !== 3'b000) begin n_fail++; $display("FAIL reset flags got %b exp 000", {res_c_out, res_zero, res_sign}); end
    n_checks++; if ({alu_a, alu_b, alu_c_in, alu_op, alu_l} !== 12'h000) begin
      n_fail++; $display("FAIL reset alu got %h exp 000", {alu_a, alu_b, alu_c_in, alu_op, alu_l}); end
  endtask

  task automatic test_add();
    run_op(8'h3A, 8'h07, 2'd0, 1'b0, 1'b0, 1'b0, 0, "add_3A_07");
  endtask

  task automatic test_carry_chain();
    run_op(8'hFF, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0, 0, "add_FF_01");
    run_op(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 0, "chain_00_00");
  endtask

  task automatic test_logic();
    run_op(8'hF0, 8'h0F, 2'd1, 1'b1, 1'b0, 1'b0, 0, "and_F0_0F");
    run_op(8'hC3, 8'hF0, 2'd1, 1'b1, 1'b0, 1'b0, 0, "and_C3_F0");
  endtask

  task automatic test_backpressure();
    run_op(8'h12, 8'h34, 2'd2, 1'b0, 1'b1, 1'b0, 5, "stall_12_34");
    // cmd_valid is still high here, so this command is taken in the IDLE cycle.
    run_op(8'h9C, 8'h6B, 2'd3, 1'b0, 1'b0, 1'b1, 0, "after_stall");
  endtask

  task automatic test_reset_abort();
    int n;
    run_op(8'hF0, 8'h20, 2'd0, 1'b0, 1'b0, 1'b0, 0, "pre_abort");
    cmd_a = 8'h55; cmd_b = 8'h11; cmd_l = 1'b0; cmd_cin = 1'b1; cmd_chain = 1'b0; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1; res_ready = 1'b1;   // slice-1 cycle
    @(posedge clk); #1 reset = 1'b0; res_ready = 1'b0;
    m_saved = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort cmd_ready got %b exp 1", cmd_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL abort res_valid got %b exp 0", res_valid); end
    n_checks++; if (res_r !== 8'h00)    begin n_fail++; $display("FAIL abort res_r got %h exp 00", res_r); end
    n_checks++; if (res_c_out !== 1'b0) begin n_fail++; $display("FAIL abort res_c_out got %b exp 0", res_c_out); end
    run_op(8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 0, "chain_after_reset");
  endtask

  task automatic test_back_to_back();
    b2b = 1'b1; have_prev = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, "b2b");
    b2b = 1'b0; have_prev = 1'b0; res_ready = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), "random");
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_logic();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run ends even if the design stops responding.
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
